irq_aggregator: RTL



---
 rtl/irq_aggregator_pkg.sv | 23 ++
 rtl/irq_aggregator_if.sv | 12 +
 rtl/irq_src_cell.sv | 35 +++
 rtl/irq_aggregator.sv | 82 ++++++++
 4 files changed

// File: rtl/irq_aggregator_pkg.sv
// Register map constants and the priority helper shared by the interrupt
// aggregator and its bench.
package irq_aggregator_pkg;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_MODE    = 3'd2;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
   localparam logic [2:0] ADDR_EVCOUNT = 3'd4;

   localparam int          ACTIVE_VALID_BIT = 15;
   localparam logic [15:0] EVCOUNT_MAX      = 16'hFFFF;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) idx = 4'(i);
      return idx;
   endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave port of the interrupt aggregator: 3-bit word address,
// 16-bit data, registered read.
interface irq_aggregator_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_src_cell.sv
// Per-source state: input history for edge detection and the pending flop,
// which either follows the input (level) or latches edges until cleared.
module irq_src_cell (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   input  logic mode,
   input  logic w1c,
   output logic pending,
   output logic edge_set
);

   logic irq_prev;
   logic rise;

   assign rise     = irq_in & ~irq_prev;
   assign edge_set = mode & rise;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_prev <= 1'b0;
         pending  <= 1'b0;
      end else begin
         irq_prev <= irq_in;
         if (mode) begin
            // a new edge beats a simultaneous software clear
            if (rise)     pending <= 1'b1;
            else if (w1c) pending <= 1'b0;
         end else begin
            pending <= irq_in;
         end
      end
   end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source level/edge capture, masking, priority
// report, edge event counter and a registered interrupt to the CPU.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int N_SRC = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   irq_aggregator_if.slave      bus,
   input  logic [N_SRC-1:0]     irq_in,
   output logic                 irq_out
);

   logic [N_SRC-1:0] mask, mode, pending, edge_set, w1c;
   logic [15:0]      evcount;
   logic [15:0]      pend16, mask16, mode16, masked16, active16, rd_mux;
   logic             wr;
   logic             unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign w1c       = (wr && bus.address == ADDR_PENDING) ? bus.writedata[N_SRC-1:0] : '0;
   assign unused_wd = ^bus.writedata;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      irq_src_cell u_cell (
         .clk      (clk),
         .reset    (reset),
         .irq_in   (irq_in[i]),
         .mode     (mode[i]),
         .w1c      (w1c[i]),
         .pending  (pending[i]),
         .edge_set (edge_set[i])
      );
   end

   assign pend16   = 16'(pending);
   assign mask16   = 16'(mask);
   assign mode16   = 16'(mode);
   assign masked16 = pend16 & mask16;

   always_comb begin
      active16 = '0;
      if (|masked16) begin
         active16[ACTIVE_VALID_BIT] = 1'b1;
         active16[3:0]              = lowest_set(masked16);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_PENDING: rd_mux = pend16;
         ADDR_MASK:    rd_mux = mask16;
         ADDR_MODE:    rd_mux = mode16;
         ADDR_ACTIVE:  rd_mux = active16;
         ADDR_EVCOUNT: rd_mux = evcount;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask         <= '0;
         mode         <= '0;
         evcount      <= '0;
         bus.readdata <= '0;
         irq_out      <= 1'b0;
      end else begin
         bus.readdata <= rd_mux;
         irq_out      <= |(pending & mask);
         if (wr && bus.address == ADDR_MASK) mask <= bus.writedata[N_SRC-1:0];
         if (wr && bus.address == ADDR_MODE) mode <= bus.writedata[N_SRC-1:0];
         // software clear takes priority over a same-cycle event
         if (wr && bus.address == ADDR_EVCOUNT)
            evcount <= '0;
         else if (|edge_set && evcount != EVCOUNT_MAX)
            evcount <= evcount + 16'd1;
      end
   end

endmodule
